// File: rtl/systolic_feed_if.sv
// Operand-feed bus between a systolic feed sequencer (master) and its host/memories (slave).
// With ABORT_EN defined the bus also carries abort/aborted.
interface systolic_feed_if #(
    parameter int A_ROWS = 2,
    parameter int A_COLS = 3,
    parameter int B_COLS = 2
);
    localparam int AW = (A_ROWS * A_COLS > 1) ? $clog2(A_ROWS * A_COLS) : 1;
    localparam int BW = (A_COLS * B_COLS > 1) ? $clog2(A_COLS * B_COLS) : 1;

    logic                   start;
    logic                   busy;
    logic                   clear_acc;
    logic [A_ROWS-1:0]      a_rd_en;
    logic [A_ROWS*AW-1:0]   a_addr;
    logic [B_COLS-1:0]      b_rd_en;
    logic [B_COLS*BW-1:0]   b_addr;
    logic                   done;
`ifdef ABORT_EN
    logic                   abort;
    logic                   aborted;

    modport master (
        input  start, abort,
        output busy, clear_acc, a_rd_en, a_addr, b_rd_en, b_addr, done, aborted
    );
    modport slave (
        output start, abort,
        input  busy, clear_acc, a_rd_en, a_addr, b_rd_en, b_addr, done, aborted
    );
`else
    modport master (
        input  start,
        output busy, clear_acc, a_rd_en, a_addr, b_rd_en, b_addr, done
    );
    modport slave (
        output start,
        input  busy, clear_acc, a_rd_en, a_addr, b_rd_en, b_addr, done
    );
`endif
endinterface

// File: rtl/systolic_feed_controller.sv
// Skewed A/B operand-feed sequencer for an output-stationary systolic array.
// Optional feature: define ABORT_EN to add the abort input / aborted pulse.
module systolic_feed_controller #(
    parameter int A_ROWS = 2,
    parameter int A_COLS = 3,
    parameter int B_COLS = 2,
    parameter int PE_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    systolic_feed_if.master bus
);
    localparam int AW        = (A_ROWS * A_COLS > 1) ? $clog2(A_ROWS * A_COLS) : 1;
    localparam int BW        = (A_COLS * B_COLS > 1) ? $clog2(A_COLS * B_COLS) : 1;
    localparam int MAX_RC    = (A_ROWS > B_COLS) ? A_ROWS : B_COLS;
    localparam int FEED_LEN  = A_COLS + MAX_RC - 1;
    localparam int DRAIN_LEN = A_ROWS + B_COLS - 2 + PE_LAT;
    // Wide enough for the step count and for every unskewed address sum.
    localparam int CW = $clog2(FEED_LEN + DRAIN_LEN + A_ROWS * A_COLS + A_COLS * B_COLS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

    logic [1:0]          state;
    logic [CW-1:0]       step;
    logic                active;
    logic                abort_hit;
    logic signed [CW:0]  k;
    logic [CW-1:0]       addr;
    logic [A_ROWS-1:0]    a_en;
    logic [A_ROWS*AW-1:0] a_ad;
    logic [B_COLS-1:0]    b_en;
    logic [B_COLS*BW-1:0] b_ad;

    assign active = (state == S_FEED) || (state == S_DRAIN);

`ifdef ABORT_EN
    logic aborted_q;
    assign abort_hit   = bus.abort && active;
    assign bus.aborted = aborted_q;

    always_ff @(posedge clk) begin
        if (reset) aborted_q <= 1'b0;
        else       aborted_q <= abort_hit;
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            step  <= '0;
        end else if (abort_hit) begin
            state <= S_IDLE;
            step  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_FEED;
                        step  <= '0;
                    end
                end
                S_FEED: begin
                    if (step == FEED_LAST) begin
                        state <= (DRAIN_LEN == 0) ? S_DONE : S_DRAIN;
                        step  <= '0;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (step == DRAIN_LAST) begin
                        state <= S_DONE;
                        step  <= '0;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    step  <= '0;
                end
            endcase
        end
    end

    // Lane r/c sees inner index k = step - lane; lanes outside 0..A_COLS-1 stay idle with address 0.
    always_comb begin
        a_en = '0;
        a_ad = '0;
        b_en = '0;
        b_ad = '0;
        k    = '0;
        addr = '0;
        if (state == S_FEED) begin
            for (int r = 0; r < A_ROWS; r++) begin
                k = $signed({1'b0, step}) - $signed((CW+1)'(r));
                if (k >= 0 && k < $signed((CW+1)'(A_COLS))) begin
                    a_en[r]          = 1'b1;
                    addr             = CW'(r * A_COLS) + CW'(k);
                    a_ad[r*AW +: AW] = addr[AW-1:0];
                end
            end
            for (int c = 0; c < B_COLS; c++) begin
                k = $signed({1'b0, step}) - $signed((CW+1)'(c));
                if (k >= 0 && k < $signed((CW+1)'(A_COLS))) begin
                    b_en[c]          = 1'b1;
                    addr             = CW'(k) * CW'(B_COLS) + CW'(c);
                    b_ad[c*BW +: BW] = addr[BW-1:0];
                end
            end
        end
    end

    assign bus.busy      = active;
    assign bus.clear_acc = (state == S_FEED) && (step == '0);
    assign bus.done      = (state == S_DONE);
    assign bus.a_rd_en   = a_en;
    assign bus.a_addr    = a_ad;
    assign bus.b_rd_en   = b_en;
    assign bus.b_addr    = b_ad;
endmodule
